mult_seq_param: RTL and testbench

Parametrised sequential multiplier with an integrated controller. It computes a WIDTH×WIDTH signed or unsigned product by accumulating CHUNK×CHUNK partial products, one per cycle, into a 2·WIDTH-bit register. It replaces the fixed 32×32 arithmetic unit and its external controller: the FSM, the operand capture and the sign handling all sit inside this block. A start/busy/done handshake connects it to the surrounding datapath.

---
 rtl/mult_seq_param.sv | 147 ++++++++++++++
 tb/tb_mult_seq_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// Sequential WIDTH x WIDTH signed/unsigned multiplier built from CHUNK x CHUNK partial products.
// Latency N*N+2 cycles from accepted start to done; start is ignored while busy, abort cancels.
module mult_seq_param #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / CHUNK;
  localparam int PW = 2 * WIDTH;
  localparam int KW = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N * N - 1);
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_q, neg_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0]   a_ch [N];
  logic [CHUNK-1:0]   b_ch [N];
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      pp_sh;

  for (genvar g = 0; g < N; g++) begin : g_chunk
    assign a_ch[g] = a_q[g*CHUNK +: CHUNK];
    assign b_ch[g] = b_q[g*CHUNK +: CHUNK];
  end

  // i walks the multiplicand chunks slowly, j the multiplier chunks quickly; k = i*N + j
  assign pp    = (2*CHUNK)'(a_ch[i_q]) * (2*CHUNK)'(b_ch[j_q]);
  assign pp_sh = PW'(pp) << (CHUNK * (int'(i_q) + int'(j_q)));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // magnitude of the most-negative value still fits unsigned in WIDTH bits
          a_d     = (is_signed && a[WIDTH-1]) ? -a : a;
          b_d     = (is_signed && b[WIDTH-1]) ? -b : b;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          prod_d  = '0;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        prod_d = prod_q + pp_sh;
        if (j_q == C_LAST) begin
          j_d = '0;
          i_d = (i_q == C_LAST) ? '0 : i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_FIX;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_FIX: begin
        prod_d  = neg_q ? -prod_q : prod_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort outranks any transition, but only cancels work already in flight
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      prod_d  = '0;
      done_d  = 1'b0;
      k_d     = '0;
      i_d     = '0;
      j_d     = '0;
    end
  end

  assign busy_d = (state_d == S_MULT) || (state_d == S_FIX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: default 32/16 instance plus a 16/4 instance.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, is_signed = 1'b0, abort = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [63:0] product;

  logic        start2 = 1'b0, is_signed2 = 1'b0, abort2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [31:0] product2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(32), .CHUNK(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  mult_seq_param #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .is_signed(is_signed2), .abort(abort2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start in cycle 0, return at the negedge of the done cycle; lat counts cycles to done.
  task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                    output logic [63:0] p, output int lat);
    @(negedge clk);
    a = ia; b = ib; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = product;
  endtask

  task automatic op2(input logic [15:0] ia, input logic [15:0] ib, input logic s,
                     output logic [31:0] p, output int lat);
    @(negedge clk);
    a2 = ia; b2 = ib; is_signed2 = s; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (done2 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = product2;
  endtask

  initial begin
    logic [63:0]        p;
    logic [31:0]        p2;
    logic [31:0]        exp2;
    logic [15:0]        ra, rb;
    logic signed [31:0] sa, sb;
    logic               s;
    int                 lat;
    int                 cnt;

    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("idle_busy", busy, 1'b0);
    check("idle_product2", product2, 32'h0);

    // unsigned max, cycle by cycle
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; is_signed = 1'b0; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("umax_busy_c%0d", c), busy, (c <= 5));
      check($sformatf("umax_done_c%0d", c), done, (c == 6));
      if (c == 1) check("umax_product_c1", product, 64'h0);
    end
    check("umax_product", product, 64'hFFFF_FFFE_0000_0001);

    op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, p, lat);
    check("smix_product", p, 64'hFFFF_FFFF_FFFF_FFF1);
    check("smix_lat", lat, 6);
    op(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat);
    check("smin_product", p, 64'h4000_0000_0000_0000);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat);
    check("sneg1_product", p, 64'h1);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat);
    check("uneg1_product", p, 64'hFFFF_FFFE_0000_0001);

    // start held with new operands while busy
    @(negedge clk);
    a = 32'd7; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'd3; b = 32'hFFFF_FFFD; is_signed = 1'b1;
    for (int c = 2; c <= 4; c++) @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold_lat", lat, 6);
    check("hold_product", product, 64'd63);

    // back-to-back: start in the done cycle
    a = 32'h0001_0000; b = 32'h0001_0000; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_pulse", done, 1'b0);
    check("b2b_busy", busy, 1'b1);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat", lat, 6);
    check("b2b_product", product, 64'h1_0000_0000);
    @(negedge clk);
    check("b2b_done_end", done, 1'b0);

    // abort in cycle 3
    a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_product", product, 64'h0);
    check("abort_done", done, 1'b0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // abort in idle does nothing; start+abort in idle starts
    op(32'h10, 32'h20, 1'b0, p, lat);
    check("small_product", p, 64'h200);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_hold", product, 64'h200);
    a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFE; is_signed = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", busy, 1'b1);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("startabort_lat", lat, 6);
    check("startabort_product", product, 64'd4);

    // async reset in cycle 2
    @(negedge clk);
    a = 32'h1234; b = 32'h5678; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_product", product, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, p, lat);
    check("post_rst_product", p, 64'hFFFE_0001);
    check("post_rst_lat", lat, 6);

    // 16/4 instance
    op2(16'hFFFF, 16'hFFFF, 1'b0, p2, lat);
    check("w16_umax", p2, 32'hFFFE_0001);
    check("w16_lat", lat, 18);
    op2(16'h8000, 16'h8000, 1'b1, p2, lat);
    check("w16_smin", p2, 32'h4000_0000);
    op2(16'hFFFF, 16'h0007, 1'b1, p2, lat);
    check("w16_sneg", p2, 32'hFFFF_FFF9);
    op2(16'h0000, 16'h1234, 1'b1, p2, lat);
    check("w16_zero", p2, 32'h0);
    op2(16'h0001, 16'hABCD, 1'b0, p2, lat);
    check("w16_one_u", p2, 32'h0000_ABCD);
    op2(16'h0001, 16'hABCD, 1'b1, p2, lat);
    check("w16_one_s", p2, 32'hFFFF_ABCD);
    for (int t = 0; t < 8; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      s  = t[0];
      sa = $signed(ra);
      sb = $signed(rb);
      exp2 = s ? 32'(sa * sb) : ({16'h0, ra} * {16'h0, rb});
      op2(ra, rb, s, p2, lat);
      check($sformatf("w16_rand%0d", t), p2, exp2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
